// File: rtl/rf_wport_arbiter_if.sv
// Bundle between the pipeline/long-latency units and the RF write-port arbiter.
// master: stage 5, unit return path and hazard unit; slave: the arbiter itself.
interface rf_wport_arbiter_if;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        lu_valid;
    logic [4:0]  lu_dest;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        pipe_stall;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  q_rs;
    logic [4:0]  q_rt;
    logic        q_hit;
    logic [2:0]  pend_count;

    modport master (
        output wb_valid, wb_dest, wb_data,
        output lu_valid, lu_dest, lu_data,
        output q_rs, q_rt,
        input  lu_ready, pipe_stall, q_hit, pend_count,
        input  rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input  wb_valid, wb_dest, wb_data,
        input  lu_valid, lu_dest, lu_data,
        input  q_rs, q_rt,
        output lu_ready, pipe_stall, q_hit, pend_count,
        output rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rf_wport_arbiter.sv
// Shares the RF write port between stage-5 writeback and a FIFO of unit returns.
// Ports: clk, rst_n (sync, active low), bus (slave side of rf_wport_arbiter_if).
module rf_wport_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    rf_wport_arbiter_if.slave   bus
);
    localparam int         PW     = (DEPTH == 4) ? 2 : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);
    localparam logic [3:0] SMAX    = 4'(STARVE_MAX);

    logic [4:0]    q_dest [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    count;
    logic [3:0]    starve;
    logic          stall;
    logic          we;
    logic [4:0]    waddr;
    logic [31:0]   wdata;

    logic          wb_eff, nonempty, full, enq, pop;
    logic [2:0]    count_d;
    logic [3:0]    starve_d;
    logic          stall_d;
    logic          we_d;
    logic [4:0]    waddr_d;
    logic [31:0]   wdata_d;
    logic [PW-1:0] off;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            starve <= '0;
            stall  <= 1'b0;
            we     <= 1'b0;
            waddr  <= '0;
            wdata  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count  <= count_d;
            starve <= starve_d;
            stall  <= stall_d;
            we     <= we_d;
            waddr  <= waddr_d;
            wdata  <= wdata_d;
        end
    end

    // Entry storage needs no reset: validity comes from count/pointers
    always_ff @(posedge clk) begin
        if (enq) begin
            q_dest[wr_ptr] <= bus.lu_dest;
            q_data[wr_ptr] <= bus.lu_data;
        end
    end

    // Next-state logic
    always_comb begin
        wb_eff   = bus.wb_valid && (bus.wb_dest != 5'd0);
        nonempty = (count != 3'd0);
        full     = (count == DEPTH_C);
        // dest-0 returns are handshaken but silently dropped
        enq      = bus.lu_valid && !full && (bus.lu_dest != 5'd0);
        pop      = nonempty && (stall || !wb_eff);
        count_d  = count + {2'b0, enq} - {2'b0, pop};

        starve_d = starve;
        if (!nonempty || pop)
            starve_d = '0;
        else if (starve != 4'hF)
            starve_d = starve + 4'd1;

        // head already waited STARVE_MAX cycles and is passed over again
        stall_d = nonempty && !pop && (starve >= SMAX);

        we_d    = 1'b0;
        waddr_d = waddr;
        wdata_d = wdata;
        if (pop) begin
            we_d    = 1'b1;
            waddr_d = q_dest[rd_ptr];
            wdata_d = q_data[rd_ptr];
        end else if (wb_eff) begin
            we_d    = 1'b1;
            waddr_d = bus.wb_dest;
            wdata_d = bus.wb_data;
        end
    end

    // Outputs
    always_comb begin
        bus.lu_ready   = (count < DEPTH_C);
        bus.pipe_stall = stall;
        bus.pend_count = count;
        bus.rf_we      = we;
        bus.rf_waddr   = waddr;
        bus.rf_wdata   = wdata;
        bus.q_hit      = 1'b0;
        off            = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // slot i is live when its distance from the head is below count
            off = PW'(i) - rd_ptr;
            if ((3'(off) < count) && (q_dest[i] != 5'd0) &&
                ((q_dest[i] == bus.q_rs) || (q_dest[i] == bus.q_rt)))
                bus.q_hit = 1'b1;
        end
    end
endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed bench for rf_wport_arbiter with a queue-based reference model.
// Ports: none (top-level testbench).
module tb_rf_wport_arbiter;
    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    rf_wport_arbiter_if bus();

    rf_wport_arbiter #(
        .DEPTH(DEPTH),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    int          passed  = 0;
    bit          m_stall = 0;
    bit          m_we    = 0;
    bit          m_fresh = 0;
    bit          m_on    = 0;
    logic [4:0]  m_addr  = '0;
    logic [31:0] m_data  = '0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        bit hit;
        hit = 0;
        foreach (mq[i])
            if (mq[i].dest == bus.q_rs || mq[i].dest == bus.q_rt) hit = 1;
        chk("lu_ready", 32'(bus.lu_ready), 32'(mq.size() < DEPTH));
        chk("pend_count", 32'(bus.pend_count), 32'(mq.size()));
        chk("pipe_stall", 32'(bus.pipe_stall), 32'(m_stall));
        chk("q_hit", 32'(bus.q_hit), 32'(hit));
        chk("rf_we", 32'(bus.rf_we), 32'(m_we));
        if (m_we || m_fresh) begin
            chk("rf_waddr", 32'(bus.rf_waddr), 32'(m_addr));
            chk("rf_wdata", bus.rf_wdata, m_data);
        end
    endtask

    task automatic advance_model();
        bit   wb_e, room, had, served;
        ent_t e;
        wb_e   = bus.wb_valid && (bus.wb_dest != 0);
        room   = mq.size() < DEPTH;
        had    = mq.size() > 0;
        served = 0;
        if (had && (m_stall || !wb_e)) begin
            e       = mq.pop_front();
            m_we    = 1;
            m_addr  = e.dest;
            m_data  = e.data;
            m_fresh = 0;
            served  = 1;
        end else if (wb_e) begin
            m_we    = 1;
            m_addr  = bus.wb_dest;
            m_data  = bus.wb_data;
            m_fresh = 0;
        end else begin
            m_we = 0;
        end
        if (bus.lu_valid && room && bus.lu_dest != 0) begin
            e.dest = bus.lu_dest;
            e.data = bus.lu_data;
            mq.push_back(e);
        end
        // number of consecutive cycles the current head was passed over
        if (!had || served) passed = 0;
        else passed++;
        m_stall = (passed > STARVE_MAX);
    endtask

    task automatic cyc(bit wv, logic [4:0] wd, logic [31:0] wdat,
                       bit lv, logic [4:0] ld, logic [31:0] ldat,
                       logic [4:0] rs = 5'd0, logic [4:0] rt = 5'd0);
        bus.wb_valid = wv;
        bus.wb_dest  = wd;
        bus.wb_data  = wdat;
        bus.lu_valid = lv;
        bus.lu_dest  = ld;
        bus.lu_data  = ldat;
        bus.q_rs     = rs;
        bus.q_rt     = rt;
        #1;
        if (m_on) compare_model();
        if (!rst_n) begin
            mq.delete();
            passed  = 0;
            m_stall = 0;
            m_we    = 0;
            m_addr  = '0;
            m_data  = '0;
            m_fresh = 1;
            m_on    = 1;
        end else begin
            advance_model();
        end
        @(negedge clk);
    endtask

    initial begin
        bus.wb_valid = 0; bus.wb_dest = 0; bus.wb_data = 0;
        bus.lu_valid = 0; bus.lu_dest = 0; bus.lu_data = 0;
        bus.q_rs = 0; bus.q_rt = 0;
        @(negedge clk);

        // reset with a unit presenting data
        rst_n = 0;
        cyc(0, 0, 0, 1, 5'd3, 32'h33);
        cyc(0, 0, 0, 1, 5'd3, 32'h33);
        chk("rst_we", 32'(bus.rf_we), 0);
        chk("rst_ready", 32'(bus.lu_ready), 1);
        chk("rst_pend", 32'(bus.pend_count), 0);
        chk("rst_stall", 32'(bus.pipe_stall), 0);
        chk("rst_waddr", 32'(bus.rf_waddr), 0);
        chk("rst_wdata", bus.rf_wdata, 0);
        rst_n = 1;
        cyc(0, 0, 0, 0, 0, 0);

        // priority
        cyc(0, 0, 0, 1, 5'd7, 32'h77);
        chk("pri_pend1", 32'(bus.pend_count), 1);
        cyc(1, 5'd5, 32'hAAAA0001, 0, 0, 0);
        chk("pri_wb_we", 32'(bus.rf_we), 1);
        chk("pri_wb_addr", 32'(bus.rf_waddr), 5);
        chk("pri_wb_data", bus.rf_wdata, 32'hAAAA0001);
        cyc(0, 0, 0, 0, 0, 0);
        chk("pri_lu_addr", 32'(bus.rf_waddr), 7);
        chk("pri_lu_data", bus.rf_wdata, 32'h77);
        chk("pri_pend0", 32'(bus.pend_count), 0);

        // full
        cyc(1, 5'd10, 32'h1010, 1, 5'd3, 32'h33);
        cyc(1, 5'd10, 32'h1010, 1, 5'd4, 32'h44);
        chk("full_ready", 32'(bus.lu_ready), 0);
        cyc(1, 5'd10, 32'h1010, 1, 5'd6, 32'h66);
        chk("full_pend", 32'(bus.pend_count), 2);
        cyc(0, 0, 0, 0, 0, 0);
        chk("full_drain1", 32'(bus.rf_waddr), 3);
        cyc(0, 0, 0, 0, 0, 0);
        chk("full_drain2", 32'(bus.rf_waddr), 4);
        chk("full_empty", 32'(bus.pend_count), 0);

        // starvation
        cyc(1, 5'd11, 32'hB0B0, 1, 5'd8, 32'h88);
        for (int k = 1; k <= 7; k++) begin
            cyc(1, 5'd11, 32'hB0B0, 0, 0, 0);
            chk("starve_stall", 32'(bus.pipe_stall), 32'(k == 5));
            if (k == 6) begin
                chk("starve_addr", 32'(bus.rf_waddr), 8);
                chk("starve_data", bus.rf_wdata, 32'h88);
            end
            if (k == 7) begin
                chk("starve_resume", 32'(bus.rf_waddr), 11);
                chk("starve_pend", 32'(bus.pend_count), 0);
            end
        end

        // register 0 filter
        for (int k = 0; k < 3; k++) begin
            cyc(1, 5'd0, 32'hDEAD, 1, 5'd0, 32'hBEEF);
            chk("r0_we", 32'(bus.rf_we), 0);
            chk("r0_pend", 32'(bus.pend_count), 0);
            chk("r0_hit", 32'(bus.q_hit), 0);
        end

        // scoreboard
        cyc(1, 5'd12, 32'hC0C0, 1, 5'd9, 32'h99);
        cyc(1, 5'd12, 32'hC0C0, 0, 0, 0, 5'd9, 5'd0);
        chk("sb_hit_rs", 32'(bus.q_hit), 1);
        cyc(0, 0, 0, 0, 0, 0, 5'd9, 5'd0);
        chk("sb_pend0", 32'(bus.pend_count), 0);
        chk("sb_clear", 32'(bus.q_hit), 0);
        chk("sb_addr", 32'(bus.rf_waddr), 9);
        cyc(1, 5'd12, 32'hC0C0, 1, 5'd14, 32'hEE);
        cyc(1, 5'd12, 32'hC0C0, 0, 0, 0, 5'd0, 5'd14);
        chk("sb_hit_rt", 32'(bus.q_hit), 1);
        cyc(0, 0, 0, 0, 0, 0);

        // reset mid-operation
        cyc(1, 5'd13, 32'h1313, 1, 5'd15, 32'h1515);
        cyc(1, 5'd13, 32'h1313, 1, 5'd16, 32'h1616);
        rst_n = 0;
        cyc(1, 5'd13, 32'h1313, 1, 5'd17, 32'h1717);
        rst_n = 1;
        chk("mrst_pend", 32'(bus.pend_count), 0);
        chk("mrst_we", 32'(bus.rf_we), 0);
        chk("mrst_ready", 32'(bus.lu_ready), 1);
        cyc(0, 0, 0, 0, 0, 0);
        chk("mrst_nowrite", 32'(bus.rf_we), 0);

        // mixed traffic: wrap, simultaneous enq/pop, starvation under load
        for (int i = 0; i < 48; i++) begin
            cyc((i % 3) != 0, 5'(i % 7), 32'hC000_0000 + 32'(i),
                ((i % 2) == 0) || ((i % 5) == 0), 5'((i * 3) % 11),
                32'hD000_0000 + 32'(i), 5'(i % 13), 5'((i + 4) % 9));
        end
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/rf_wport_arbiter.md
Name: rf_wport_arbiter

Overview:
- Shares the single register-file write port between two requesters.
  - Stage-5 writeback: the result already selected by the WB select logic.
  - Long-latency unit returns: multiply/divide HI/LO moves and late load returns.
- Unit returns are queued in a small FIFO. Stage 5 normally has priority.
- A starvation counter forces a FIFO drain by stalling the pipeline for one cycle.
- Exports a pending-destination scoreboard hit so the hazard unit can interlock readers of queued registers.

Parameters:
- DEPTH, 2, number of FIFO entries for unit returns; legal values 2 or 4.
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO head may go unserviced before a forced drain; legal range 1..15.

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- wb_valid  input  1  stage 5 has a register write this cycle.
- wb_dest  input  5  stage-5 destination register.
- wb_data  input  32  stage-5 write data.
- lu_valid  input  1  long-latency unit presents a result.
- lu_dest  input  5  unit destination register.
- lu_data  input  32  unit result data.
- lu_ready  output  1  FIFO can accept; a transfer occurs when lu_valid and lu_ready are both high at a clock edge.
- pipe_stall  output  1  stage 5 must hold its instruction this cycle; the port is given to the FIFO head.
- rf_we  output  1  register-file write enable (registered).
- rf_waddr  output  5  register-file write address (registered).
- rf_wdata  output  32  register-file write data (registered).
- q_rs  input  5  hazard query, source register rs.
- q_rt  input  5  hazard query, source register rt.
- q_hit  output  1  combinational; high when q_rs or q_rt equals the dest of any valid FIFO entry, excluding register 0.
- pend_count  output  3  number of valid FIFO entries.

Behaviour:
- Reset (rst_n low at an edge) clears outputs and state:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - pipe_stall=0, pend_count=0, starvation counter=0, FIFO pointers=0.
  - lu_ready=1. q_hit=0 because the FIFO is empty.
- Reset mid-operation discards all queued entries; no partial write issues.
- Register 0 filter:
  - Writes with dest 0 never reach the port and never count toward q_hit.
  - wb_dest=0 is treated as wb_valid=0.
  - lu_dest=0 is accepted when lu_ready is high, then dropped (not enqueued).
- lu_ready = (pend_count < DEPTH), computed from registered count only.
  - When full, no enqueue occurs even if the head pops in the same cycle.
- Port selection, evaluated each cycle from current state and inputs; the winner is registered into rf_* at the edge (1-cycle latency):
  - If pipe_stall=1: FIFO head wins, pop.
  - Else if wb_valid (dest≠0): stage 5 wins.
  - Else if FIFO non-empty: head wins, pop.
  - Else: rf_we=0 next cycle.
- A simultaneous enqueue and pop on a non-full FIFO leaves pend_count unchanged; pointers wrap modulo DEPTH.
- Starvation counter:
  - Clears on any pop or when the FIFO is empty.
  - Otherwise increments (saturating) each cycle the FIFO is non-empty and the head does not pop.
  - pipe_stall is registered: set the cycle after the counter reaches STARVE_MAX; held exactly one cycle (the forced pop clears the counter).
- FIFO order is strict: entries drain in acceptance order.
- The stage-5 vs queued-entry same-dest ordering is the hazard unit's responsibility via q_hit; this block does not reorder.
- pend_count reflects state after the previous edge.

Test Plan:
- Reset: hold rst_n=0 two cycles with lu_valid=1 → rf_we=0, lu_ready=1, pend_count=0, no entries accepted.
- Priority: wb_valid=1 (dest 5, data 0xAAAA0001) with one queued lu entry (dest 7, 0x77) →
  - rf_we=1 / waddr 5 next cycle.
  - When wb_valid drops: waddr 7, data 0x77; pend_count 1→0.
- Full: DEPTH=2, enqueue dest 3 and dest 4 while wb_valid is held high → lu_ready=0; a third lu_valid is not accepted and pend_count stays 2.
- Starvation: STARVE_MAX=4, one queued entry, wb_valid continuously high →
  - pipe_stall=1 for exactly one cycle, 5 cycles after the enqueue.
  - The queued entry is written next; stage 5 resumes afterwards.
- Reg 0: wb_dest=0 and lu_dest=0 transfers → rf_we never asserts, pend_count stays 0, q_hit=0 with q_rs=0.
- Scoreboard: queued dest 9, q_rs=9 → q_hit=1; after the drain write, q_hit=0 in the same cycle pend_count reaches 0.
